// File: rtl/pong_game_ctrl.sv
// Game-flow controller for single-player Pong: serve sequencing, paddle hit/miss
// detection, BCD score and lives bookkeeping. All outputs are registered.
module pong_game_ctrl #(
    parameter int SERVE_DELAY = 50_000_000,
    parameter int LIVES       = 3,
    parameter int PADDLE_Y    = 440,
    parameter int PADDLE_W    = 64,
    parameter int Y_MAX       = 479
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Space,
    input  logic [10:0] i_Ball_X,
    input  logic [10:0] i_Ball_Y,
    input  logic        i_Ball_Dir_Y,
    input  logic [10:0] i_Paddle_X,
    output logic        o_Ball_Reset,
    output logic        o_Ball_Space,
    output logic        o_Paddle_Hit,
    output logic        o_Lose,
    output logic [7:0]  o_Score,
    output logic [2:0]  o_Lives,
    output logic [2:0]  o_State,
    output logic        o_Game_Over
);

    localparam int              CNT_W      = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SERVE_DELAY - 1);
    localparam logic [10:0]     HIT_ROW    = 11'(PADDLE_Y - 1);
    localparam logic [10:0]     Y_LIMIT    = 11'(Y_MAX);
    localparam logic [11:0]     PAD_SPAN   = 12'(PADDLE_W - 1);
    localparam logic [2:0]      LIVES_INIT = 3'(LIVES);

    typedef enum logic [2:0] {
        ST_ATTRACT   = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_MISS      = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] countdown_q, countdown_d;
    logic             hit_latch_q, hit_latch_d;
    logic             space_q, space_d;
    logic             ball_reset_q, ball_reset_d;
    logic             ball_space_q, ball_space_d;
    logic             paddle_hit_q, paddle_hit_d;
    logic             lose_q, lose_d;
    logic [7:0]       score_q, score_d;
    logic [2:0]       lives_q, lives_d;
    logic             game_over_q, game_over_d;

    logic sp_rise;
    logic hit_cond;
    logic miss_cond;
    logic [11:0] ball_x_w, pad_l_w, pad_r_w;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)
            return s;
        if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    // 12-bit window compare so a paddle near the right edge cannot wrap
    assign ball_x_w  = {1'b0, i_Ball_X};
    assign pad_l_w   = {1'b0, i_Paddle_X};
    assign pad_r_w   = pad_l_w + PAD_SPAN;
    assign sp_rise   = i_Space & ~space_q;
    assign hit_cond  = i_Ball_Dir_Y && (i_Ball_Y == HIT_ROW) &&
                       (ball_x_w >= pad_l_w) && (ball_x_w <= pad_r_w);
    assign miss_cond = i_Ball_Dir_Y && (i_Ball_Y >= Y_LIMIT);

    always_comb begin
        state_d      = state_q;
        countdown_d  = countdown_q;
        hit_latch_d  = 1'b0;
        space_d      = i_Space;
        ball_reset_d = 1'b1;
        ball_space_d = 1'b0;
        paddle_hit_d = 1'b0;
        lose_d       = 1'b0;
        score_d      = score_q;
        lives_d      = lives_q;
        game_over_d  = 1'b0;

        case (state_q)
            ST_ATTRACT: begin
                if (sp_rise) begin
                    score_d     = 8'h00;
                    lives_d     = LIVES_INIT;
                    countdown_d = CNT_LOAD;
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (countdown_q == '0) begin
                    ball_reset_d = 1'b0;
                    ball_space_d = 1'b1;
                    state_d      = ST_PLAY;
                end else begin
                    countdown_d = countdown_q - CNT_W'(1);
                end
            end
            ST_PLAY: begin
                ball_reset_d = 1'b0;
                hit_latch_d  = hit_latch_q & i_Ball_Dir_Y;
                // a miss overrides a simultaneous hit
                if (miss_cond) begin
                    lose_d       = 1'b1;
                    ball_reset_d = 1'b1;
                    hit_latch_d  = 1'b0;
                    if (lives_q != 3'd0)
                        lives_d = lives_q - 3'd1;
                    state_d = ST_MISS;
                end else if (hit_cond && !hit_latch_q) begin
                    paddle_hit_d = 1'b1;
                    hit_latch_d  = 1'b1;
                    score_d      = bcd_inc(score_q);
                end
            end
            ST_MISS: begin
                if (lives_q == 3'd0) begin
                    game_over_d = 1'b1;
                    state_d     = ST_GAME_OVER;
                end else begin
                    countdown_d = CNT_LOAD;
                    state_d     = ST_SERVE;
                end
            end
            ST_GAME_OVER: begin
                game_over_d = 1'b1;
                if (sp_rise) begin
                    game_over_d = 1'b0;
                    state_d     = ST_ATTRACT;
                end
            end
            default: state_d = ST_ATTRACT;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= ST_ATTRACT;
            countdown_q  <= '0;
            hit_latch_q  <= 1'b0;
            space_q      <= 1'b0;
            ball_reset_q <= 1'b1;
            ball_space_q <= 1'b0;
            paddle_hit_q <= 1'b0;
            lose_q       <= 1'b0;
            score_q      <= 8'h00;
            lives_q      <= LIVES_INIT;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            countdown_q  <= countdown_d;
            hit_latch_q  <= hit_latch_d;
            space_q      <= space_d;
            ball_reset_q <= ball_reset_d;
            ball_space_q <= ball_space_d;
            paddle_hit_q <= paddle_hit_d;
            lose_q       <= lose_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            game_over_q  <= game_over_d;
        end
    end

    assign o_Ball_Reset = ball_reset_q;
    assign o_Ball_Space = ball_space_q;
    assign o_Paddle_Hit = paddle_hit_q;
    assign o_Lose       = lose_q;
    assign o_Score      = score_q;
    assign o_Lives      = lives_q;
    assign o_State      = state_q;
    assign o_Game_Over  = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a cycle-by-cycle vector table for a full game,
// plus hand-written sequences for BCD carry/saturation, resets and hit-vs-miss.
module tb_pong_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sp, dir, sp2, dir2;
    logic [10:0] bx, by, px, bx2, by2;

    logic        br, bs, ph, lo, go;
    logic [7:0]  sc;
    logic [2:0]  lv, st;
    logic        br2, bs2, ph2, lo2, go2;
    logic [7:0]  sc2;
    logic [2:0]  lv2, st2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(.SERVE_DELAY(4), .LIVES(3), .PADDLE_Y(440), .PADDLE_W(64), .Y_MAX(479)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Space(sp), .i_Ball_X(bx), .i_Ball_Y(by),
        .i_Ball_Dir_Y(dir), .i_Paddle_X(px), .o_Ball_Reset(br), .o_Ball_Space(bs),
        .o_Paddle_Hit(ph), .o_Lose(lo), .o_Score(sc), .o_Lives(lv), .o_State(st),
        .o_Game_Over(go));

    // hit row coincides with the miss row so both conditions can be true at once
    pong_game_ctrl #(.SERVE_DELAY(4), .LIVES(3), .PADDLE_Y(480), .PADDLE_W(64), .Y_MAX(479)) dut2 (
        .i_Clock(clk), .i_Reset(rst), .i_Space(sp2), .i_Ball_X(bx2), .i_Ball_Y(by2),
        .i_Ball_Dir_Y(dir2), .i_Paddle_X(px), .o_Ball_Reset(br2), .o_Ball_Space(bs2),
        .o_Paddle_Hit(ph2), .o_Lose(lo2), .o_Score(sc2), .o_Lives(lv2), .o_State(st2),
        .o_Game_Over(go2));

    typedef struct {
        logic        sp;
        logic [10:0] bx;
        logic [10:0] by;
        logic        dir;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [18:0] ev(input logic [2:0] s, input logic r, input logic b,
                                       input logic h, input logic l, input logic [7:0] score,
                                       input logic [2:0] lives, input logic g);
        return {s, r, b, h, l, score, lives, g};
    endfunction

    function automatic logic [18:0] pack1();
        return {st, br, bs, ph, lo, sc, lv, go};
    endfunction

    function automatic logic [18:0] pack2();
        return {st2, br2, bs2, ph2, lo2, sc2, lv2, go2};
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic add(input logic s, input logic [10:0] x, input logic [10:0] y, input logic d,
                       input logic [18:0] e);
        vec_t v;
        v.sp = s; v.bx = x; v.by = y; v.dir = d; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h {state,ball_reset,ball_space,hit,lose,score,lives,game_over}",
                     nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [10:0] x, input logic [10:0] y, input logic d);
        sp = s; bx = x; by = y; dir = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [18:0] rst_vec;
        rst_vec = ev(3'd0, 1, 0, 0, 0, 8'h00, 3'd3, 0);

        rst = 1'b1; px = 11'd100;
        sp = 0; bx = 0; by = 0; dir = 0;
        sp2 = 0; bx2 = 0; by2 = 0; dir2 = 0;

        // state, ball_reset, ball_space, hit, lose, score, lives, game_over
        add(0,   0,   0, 0, ev(0, 1, 0, 0, 0, 8'h00, 3, 0));
        add(1,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h00, 3, 0));
        add(1,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h00, 3, 0));
        add(0,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h00, 3, 0));
        add(1,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h00, 3, 0));
        add(0,   0,   0, 0, ev(2, 0, 1, 0, 0, 8'h00, 3, 0));
        add(0, 100, 439, 1, ev(2, 0, 0, 1, 0, 8'h01, 3, 0));
        add(0, 100, 439, 1, ev(2, 0, 0, 0, 0, 8'h01, 3, 0));
        add(0, 100, 300, 0, ev(2, 0, 0, 0, 0, 8'h01, 3, 0));
        add(0, 163, 439, 1, ev(2, 0, 0, 1, 0, 8'h02, 3, 0));
        add(0, 163, 300, 0, ev(2, 0, 0, 0, 0, 8'h02, 3, 0));
        add(0, 164, 439, 1, ev(2, 0, 0, 0, 0, 8'h02, 3, 0));
        add(0,  99, 439, 1, ev(2, 0, 0, 0, 0, 8'h02, 3, 0));
        add(0, 100, 438, 1, ev(2, 0, 0, 0, 0, 8'h02, 3, 0));
        add(0, 100, 439, 0, ev(2, 0, 0, 0, 0, 8'h02, 3, 0));
        add(0, 300, 479, 1, ev(3, 1, 0, 0, 1, 8'h02, 2, 0));
        add(0,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h02, 2, 0));
        add(0,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h02, 2, 0));
        add(0,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h02, 2, 0));
        add(0,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h02, 2, 0));
        add(0,   0,   0, 0, ev(2, 0, 1, 0, 0, 8'h02, 2, 0));
        add(0, 300, 479, 1, ev(3, 1, 0, 0, 1, 8'h02, 1, 0));
        add(0,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h02, 1, 0));
        add(0,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h02, 1, 0));
        add(0,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h02, 1, 0));
        add(0,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h02, 1, 0));
        add(0,   0,   0, 0, ev(2, 0, 1, 0, 0, 8'h02, 1, 0));
        add(0, 300, 500, 1, ev(3, 1, 0, 0, 1, 8'h02, 0, 0));
        add(0,   0,   0, 0, ev(4, 1, 0, 0, 0, 8'h02, 0, 1));
        add(0,   0,   0, 0, ev(4, 1, 0, 0, 0, 8'h02, 0, 1));
        add(1,   0,   0, 0, ev(0, 1, 0, 0, 0, 8'h02, 0, 0));
        add(0,   0,   0, 0, ev(0, 1, 0, 0, 0, 8'h02, 0, 0));
        add(1,   0,   0, 0, ev(1, 1, 0, 0, 0, 8'h00, 3, 0));

        repeat (2) step();
        chk("reset_state", pack1(), rst_vec);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].sp, tbl[i].bx, tbl[i].by, tbl[i].dir);
            step();
            chk($sformatf("vec%0d", i), pack1(), tbl[i].exp);
        end

        // reset in the middle of the serve countdown
        drive(0, 0, 0, 0);
        step();
        chk("serve_cnt", pack1(), ev(1, 1, 0, 0, 0, 8'h00, 3, 0));
        #1 rst = 1'b1;
        #1 chk("rst_serve_async", pack1(), rst_vec);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_serve_hold%0d", i), pack1(), rst_vec);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("no_launch%0d", i), pack1(), rst_vec);
        end

        // start a game, then run 100 hits to cover 09->10 and 99 saturation
        drive(1, 0, 0, 0);
        step();
        chk("start2", pack1(), ev(1, 1, 0, 0, 0, 8'h00, 3, 0));
        drive(0, 0, 0, 0);
        repeat (3) step();
        step();
        chk("launch2", pack1(), ev(2, 0, 1, 0, 0, 8'h00, 3, 0));
        for (int k = 1; k <= 100; k++) begin
            int prev, cur;
            prev = (k - 1 > 99) ? 99 : k - 1;
            cur  = (k > 99) ? 99 : k;
            drive(0, 120, 300, 0);
            step();
            chk($sformatf("rise%0d", k), pack1(), ev(2, 0, 0, 0, 0, to_bcd(prev), 3, 0));
            drive(0, 120, 439, 1);
            step();
            chk($sformatf("hit%0d", k), pack1(), ev(2, 0, 0, 1, 0, to_bcd(cur), 3, 0));
        end

        // reset in the middle of play with a hit condition pending
        drive(0, 120, 300, 0);
        step();
        drive(0, 120, 439, 1);
        rst = 1'b1;
        #1 chk("rst_play_async", pack1(), rst_vec);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_play_hold%0d", i), pack1(), rst_vec);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0);
        step();
        chk("rst_play_after", pack1(), rst_vec);

        // hit and miss in the same cycle: miss wins
        sp2 = 1;
        step();
        chk("d2_serve", pack2(), ev(1, 1, 0, 0, 0, 8'h00, 3, 0));
        sp2 = 0;
        repeat (3) step();
        step();
        chk("d2_launch", pack2(), ev(2, 0, 1, 0, 0, 8'h00, 3, 0));
        bx2 = 11'd100; by2 = 11'd479; dir2 = 1'b1;
        step();
        chk("d2_hit_and_miss", pack2(), ev(3, 1, 0, 0, 1, 8'h00, 2, 0));
        bx2 = 0; by2 = 0; dir2 = 0;
        step();
        chk("d2_after_miss", pack2(), ev(1, 1, 0, 0, 0, 8'h00, 2, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
